// File: rtl/fifo_burst_drain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_burst_drain_pkg : shared types/constants for the burst drainer |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fifo_burst_drain_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } drain_state_e;

    localparam int OUT_BUF_DEPTH = 2;
    localparam int OUT_BUF_CNT_W = $clog2(OUT_BUF_DEPTH + 1);
    localparam int OUT_BUF_PTR_W = $clog2(OUT_BUF_DEPTH);

endpackage
`default_nettype wire

// File: rtl/fifo_burst_drain_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_burst_drain_if : FIFO read side plus valid/ready output stream |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface fifo_burst_drain_if #(
    parameter int FIFO_WIDTH = 16
) ();

    logic                  fifo_empty;
    logic                  fifo_almostempty;
    logic                  fifo_almostfull;
    logic                  fifo_full;
    logic                  fifo_underflow;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;

    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        input  fifo_empty, fifo_almostempty, fifo_almostfull, fifo_full,
        input  fifo_underflow, fifo_data_out,
        output fifo_rd_en,
        output m_data, m_valid, m_last,
        input  m_ready
    );

    modport slave (
        output fifo_empty, fifo_almostempty, fifo_almostfull, fifo_full,
        output fifo_underflow, fifo_data_out,
        input  fifo_rd_en,
        input  m_data, m_valid, m_last,
        output m_ready
    );

endinterface
`default_nettype wire

// File: rtl/fifo_burst_drain_out_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_burst_drain_out_buf : 2-entry {last,data} skid FIFO            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fifo_burst_drain_out_buf
    import fifo_burst_drain_pkg::*;
#(
    parameter int WIDTH = 17
) (
    input  wire                      clk,
    input  wire                      rst,
    input  wire                      push_i,
    input  wire  [WIDTH-1:0]         push_data_i,
    input  wire                      pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [OUT_BUF_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]         mem_q [OUT_BUF_DEPTH];
    logic [OUT_BUF_PTR_W-1:0] wr_ptr_q;
    logic [OUT_BUF_PTR_W-1:0] rd_ptr_q;
    logic [OUT_BUF_CNT_W-1:0] cnt_q;
    logic [OUT_BUF_CNT_W-1:0] cnt_d;
    logic                     do_push;
    logic                     do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && ((cnt_q != OUT_BUF_CNT_W'(OUT_BUF_DEPTH)) || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + OUT_BUF_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - OUT_BUF_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + OUT_BUF_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + OUT_BUF_PTR_W'(1);
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_drain.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_burst_drain : drains a sync FIFO into bursts on a valid/ready  |
// | stream with m_last framing. Rev 1.0                                 |
// +--------------------------------------------------------------------+
module fifo_burst_drain
    import fifo_burst_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  wire                 clk,
    input  wire                 rst,
    fifo_burst_drain_if.master  bus,
    input  wire                 flush,
    output logic                busy,
    output logic [15:0]         words_sent,
    output logic                err_underflow
);

    localparam int TCNT_W  = $clog2(TIMEOUT);
    localparam int ICNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = FIFO_WIDTH + 1;

    drain_state_e             state_q;
    logic [TCNT_W-1:0]        tcnt_q;
    logic [ICNT_W-1:0]        icnt_q;
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic [15:0]              words_sent_q;
    logic                     err_underflow_q;

    logic [ENTRY_W-1:0]       head;
    logic [OUT_BUF_CNT_W-1:0] buf_cnt;
    logic [2:0]               occupancy;
    logic                     pop;
    logic                     credit;
    logic                     rd_en;
    logic                     rd_last;
    logic                     go_stream;

    assign pop       = bus.m_valid && bus.m_ready;
    assign occupancy = 3'(buf_cnt) + 3'(inflight_q);
    // Compare against 2+pop rather than subtracting pop, avoiding unsigned underflow.
    assign credit    = occupancy < (3'd2 + 3'(pop));
    // Read request stays combinational so it always sees the current empty flag.
    assign rd_en     = (state_q == STREAM) && !bus.fifo_empty && credit;
    assign rd_last   = (icnt_q == ICNT_W'(BURST_LEN - 1)) || bus.fifo_almostempty;
    assign go_stream = !bus.fifo_empty &&
                       (bus.fifo_almostfull || bus.fifo_full || flush ||
                        (tcnt_q == TCNT_W'(TIMEOUT - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            tcnt_q          <= '0;
            icnt_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            words_sent_q    <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_last;
            if (pop) begin
                words_sent_q <= words_sent_q + 16'd1;
            end
            if (bus.fifo_underflow) begin
                err_underflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (go_stream) begin
                        state_q <= STREAM;
                        tcnt_q  <= '0;
                        icnt_q  <= '0;
                    end else if (bus.fifo_empty) begin
                        tcnt_q <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                STREAM: begin
                    if (rd_en) begin
                        icnt_q <= icnt_q + ICNT_W'(1);
                        if (rd_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!inflight_q && (buf_cnt == '0)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    fifo_burst_drain_out_buf #(
        .WIDTH (ENTRY_W)
    ) u_out_buf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, bus.fifo_data_out}),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (buf_cnt)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (buf_cnt != '0);
    assign bus.m_data     = head[FIFO_WIDTH-1:0];
    assign bus.m_last     = head[FIFO_WIDTH] && bus.m_valid;
    assign busy           = (state_q != IDLE);
    assign words_sent     = words_sent_q;
    assign err_underflow  = err_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fifo_burst_drain : directed bench with behavioural FIFO model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fifo_burst_drain;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int BLEN  = 4;
    localparam int TOUT  = 16;

    typedef struct {
        int         nwords;
        bit         use_flush;
        logic [3:0] ready_pat;
        logic [7:0] last_mask;
        int         exp_delay;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] words_sent;
    logic        err_underflow;

    fifo_burst_drain_if #(.FIFO_WIDTH(W)) bus ();

    fifo_burst_drain #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (DEPTH),
        .BURST_LEN  (BLEN),
        .TIMEOUT    (TOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .flush         (flush),
        .busy          (busy),
        .words_sent    (words_sent),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model of the feeding FIFO: one cycle read latency.
    logic [W-1:0] fq [$];
    int           fcnt = 0;
    logic [W-1:0] dout = '0;
    logic         uf_q = 1'b0;
    logic         uf_force = 1'b0;
    logic         wr_req = 1'b0;
    logic [W-1:0] wr_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fcnt <= 0;
            uf_q <= 1'b0;
        end else begin
            uf_q <= bus.fifo_rd_en && (fq.size() == 0);
            if (bus.fifo_rd_en && (fq.size() != 0)) dout <= fq.pop_front();
            if (wr_req && (fq.size() < DEPTH)) fq.push_back(wr_data);
            fcnt <= fq.size();
        end
    end

    assign bus.fifo_empty       = (fcnt == 0);
    assign bus.fifo_almostempty = (fcnt == 1);
    assign bus.fifo_almostfull  = (fcnt == DEPTH - 1);
    assign bus.fifo_full        = (fcnt == DEPTH);
    assign bus.fifo_underflow   = uf_q | uf_force;
    assign bus.fifo_data_out    = dout;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           pat_idx = 0;
    logic [3:0]   ready_pat = 4'b1111;
    logic [W-1:0] exp_q [$];
    logic [7:0]   cur_mask = '0;
    int           rx_idx = 0;
    int           first_ne = -1;
    int           first_rd = -1;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    int           sent_exp = 0;
    int           data_ctr = 0;
    vec_t         vec [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        if (rst) begin
            prev_stall = 1'b0;
            return;
        end
        if (bus.fifo_rd_en) check("rd_en_while_empty", 32'(bus.fifo_empty), 32'd0);
        if (!bus.fifo_empty && first_ne < 0) first_ne = cyc;
        if (bus.fifo_rd_en && first_rd < 0) first_rd = cyc;
        if (prev_stall) begin
            check("stall_valid", 32'(bus.m_valid), 32'd1);
            check("stall_data", 32'(bus.m_data), 32'(prev_data));
            check("stall_last", 32'(bus.m_last), 32'(prev_last));
        end
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got=%0h want=none", bus.m_data);
            end else begin
                e = exp_q.pop_front();
                check("word_data", 32'(bus.m_data), 32'(e));
                check("word_last", 32'(bus.m_last), 32'(cur_mask[rx_idx[2:0]]));
            end
            rx_idx++;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        bus.m_ready = ready_pat[pat_idx % 4];
        pat_idx++;
        #1;
        monitor();
    endtask

    task automatic write_word(input logic [W-1:0] d);
        wr_req  = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic run_burst(input int nw, input bit fl, input logic [3:0] pat,
                             input logic [7:0] mask, input int exp_delay, input logic exp_err);
        int n;
        rx_idx    = 0;
        cur_mask  = mask;
        ready_pat = pat;
        pat_idx   = 0;
        first_ne  = -1;
        first_rd  = -1;
        for (int w = 0; w < nw; w++) begin
            write_word(16'h5A00 + 16'(data_ctr));
            data_ctr++;
        end
        if (fl) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        n = 0;
        while (rx_idx < nw && n < 300) begin
            tick();
            n++;
        end
        check("rx_count", 32'(rx_idx), 32'(nw));
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("busy_idle", 32'(busy), 32'd0);
        sent_exp += nw;
        check("words_sent", 32'(words_sent), 32'(sent_exp[15:0]));
        if (exp_delay >= 0) check("timeout_delay", 32'(first_rd - first_ne), 32'(exp_delay));
        check("err_underflow", 32'(err_underflow), 32'(exp_err));
        exp_q.delete();
    endtask

    initial begin
        vec[0] = '{5, 1'b0, 4'b1111, 8'b0001_1000, TOUT};
        vec[1] = '{3, 1'b0, 4'b1111, 8'b0000_0100, TOUT};
        vec[2] = '{8, 1'b0, 4'b1001, 8'b1000_1000, -1};
        vec[3] = '{1, 1'b1, 4'b1111, 8'b0000_0001, -1};

        bus.m_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_last", 32'(bus.m_last), 32'd0);
        check("rst_m_data", 32'(bus.m_data), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_words_sent", 32'(words_sent), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        for (int t = 0; t < 4; t++) begin
            run_burst(vec[t].nwords, vec[t].use_flush, vec[t].ready_pat,
                      vec[t].last_mask, vec[t].exp_delay, 1'b0);
        end

        // Sticky underflow error survives a following burst.
        uf_force = 1'b1;
        tick();
        uf_force = 1'b0;
        tick();
        check("err_set", 32'(err_underflow), 32'd1);
        run_burst(2, 1'b1, 4'b1111, 8'b0000_0010, -1, 1'b1);

        // Reset while the output buffer holds stalled words.
        ready_pat = 4'b0000;
        for (int w = 0; w < 8; w++) begin
            write_word(16'h3300 + 16'(w));
        end
        repeat (6) tick();
        check("pre_rst_valid", 32'(bus.m_valid), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_words", 32'(words_sent), 32'd0);
        check("mid_rst_err", 32'(err_underflow), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        sent_exp = 0;
        tick();
        check("post_rst_valid", 32'(bus.m_valid), 32'd0);
        run_burst(1, 1'b1, 4'b1111, 8'b0000_0001, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
